// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths and ALU opcodes for the operand fetch stage
package operand_fetch_pkg;

   localparam int OF_DATA_WIDTH  = 32;
   localparam int OF_ADDR_WIDTH  = 5;
   localparam int OF_IMM_WIDTH   = 16;
   localparam int OF_ALUOP_WIDTH = 3;

   typedef enum logic [OF_ALUOP_WIDTH-1:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } aluop_e;

endpackage

// File: rtl/operand_fetch_reg_file.sv
// rtl/operand_fetch_reg_file.sv - GPR file, r0 hardwired to zero, combinational reads
// Optional REGFILE_BYPASS_EN: same-cycle writeback is forwarded to the read ports.
module reg_file
   import operand_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = OF_DATA_WIDTH,
   parameter int ADDR_WIDTH = OF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wen && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0) begin
         rdata1 = regs[raddr1];
`ifdef REGFILE_BYPASS_EN
         if (wen && (waddr == raddr1)) rdata1 = wdata;
`endif
      end
      if (raddr2 != '0) begin
         rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
         if (wen && (waddr == raddr2)) rdata2 = wdata;
`endif
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode-to-execute stage: GPR read, operand B select, output register
// Optional REGFILE_BYPASS_EN (in reg_file) forwards same-cycle writebacks to rs/rt reads.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = OF_DATA_WIDTH,
   parameter int ADDR_WIDTH = OF_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_WIDTH-1:0]     in_rs,
   input  logic [ADDR_WIDTH-1:0]     in_rt,
   input  logic [OF_IMM_WIDTH-1:0]   in_imm,
   input  logic                      in_use_imm,
   input  logic                      in_sign_ext,
   input  logic [OF_ALUOP_WIDTH-1:0] in_aluop,
   input  logic [ADDR_WIDTH-1:0]     in_rd,
   input  logic                      wb_wen,
   input  logic [ADDR_WIDTH-1:0]     wb_waddr,
   input  logic [DATA_WIDTH-1:0]     wb_wdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_A,
   output logic [DATA_WIDTH-1:0]     out_B,
   output logic [OF_ALUOP_WIDTH-1:0] out_ALUop,
   output logic [ADDR_WIDTH-1:0]     out_rd
);

   logic                  accept;
   logic [DATA_WIDTH-1:0] rs_data;
   logic [DATA_WIDTH-1:0] rt_data;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] operand_b;

   reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (in_rs),
      .raddr2 (in_rt),
      .rdata1 (rs_data),
      .rdata2 (rt_data),
      .wen    (wb_wen),
      .waddr  (wb_waddr),
      .wdata  (wb_wdata)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      imm_ext = {{(DATA_WIDTH-OF_IMM_WIDTH){1'b0}}, in_imm};
      if (in_sign_ext) begin
         imm_ext = {{(DATA_WIDTH-OF_IMM_WIDTH){in_imm[OF_IMM_WIDTH-1]}}, in_imm};
      end
   end

   assign operand_b = in_use_imm ? imm_ext : rt_data;

   // A stalled entry keeps its captured operands; later writebacks do not refresh it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_A     <= '0;
         out_B     <= '0;
         out_ALUop <= '0;
         out_rd    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_A     <= rs_data;
         out_B     <= operand_b;
         out_ALUop <= in_aluop;
         out_rd    <= in_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [15:0] in_imm;
   logic        in_use_imm;
   logic        in_sign_ext;
   logic [2:0]  in_aluop;
   logic [4:0]  in_rd;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_A;
   logic [31:0] out_B;
   logic [2:0]  out_ALUop;
   logic [4:0]  out_rd;

   int vectors;
   int miscompares;
   logic [31:0] r7_expect;

   operand_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_imm      (in_imm),
      .in_use_imm  (in_use_imm),
      .in_sign_ext (in_sign_ext),
      .in_aluop    (in_aluop),
      .in_rd       (in_rd),
      .wb_wen      (wb_wen),
      .wb_waddr    (wb_waddr),
      .wb_wdata    (wb_wdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_A       (out_A),
      .out_B       (out_B),
      .out_ALUop   (out_ALUop),
      .out_rd      (out_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      in_valid    = 1'b1;
      in_rs       = 5'd3;
      in_rt       = 5'd4;
      in_imm      = 16'h0;
      in_use_imm  = 1'b0;
      in_sign_ext = 1'b0;
      in_aluop    = ALU_ADD;
      in_rd       = 5'd1;
      wb_wen      = 1'b0;
      wb_waddr    = 5'd0;
      wb_wdata    = 32'h0;
      out_ready   = 1'b1;

      step();
      step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_A", out_A, 32'h0);
      chk("rst_out_B", out_B, 32'h0);
      chk("rst_out_ALUop", out_ALUop, 3'b000);
      chk("rst_out_rd", out_rd, 5'd0);
      chk("rst_in_ready", in_ready, 1'b1);

      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         in_rs = 5'(i);
         in_rt = 5'(31 - i);
         in_rd = 5'(i);
         step();
         chk("clr_valid", out_valid, 1'b1);
         chk("clr_A", out_A, 32'h0);
         chk("clr_B", out_B, 32'h0);
      end

      in_valid = 1'b0;
      wb_wen   = 1'b1;
      wb_waddr = 5'd5;
      wb_wdata = 32'hDEADBEEF;
      step();
      chk("drain_valid", out_valid, 1'b0);

      wb_waddr = 5'd0;
      wb_wdata = 32'h12345678;
      in_valid = 1'b1;
      in_rs    = 5'd5;
      in_rt    = 5'd0;
      in_aluop = ALU_ADD;
      in_rd    = 5'd9;
      step();
      chk("r5_A", out_A, 32'hDEADBEEF);
      chk("r5_B", out_B, 32'h0);
      chk("r5_ALUop", out_ALUop, 3'b010);
      chk("r5_rd", out_rd, 5'd9);
      wb_wen = 1'b0;
      in_rs  = 5'd0;
      in_rt  = 5'd0;
      step();
      chk("r0_A", out_A, 32'h0);
      chk("r0_B", out_B, 32'h0);

      in_rs       = 5'd5;
      in_use_imm  = 1'b1;
      in_sign_ext = 1'b1;
      in_imm      = 16'h8000;
      step();
      chk("sext_B", out_B, 32'hFFFF8000);
      chk("sext_A", out_A, 32'hDEADBEEF);
      in_sign_ext = 1'b0;
      step();
      chk("zext_B", out_B, 32'h00008000);
      in_sign_ext = 1'b1;
      in_imm      = 16'h7FFF;
      step();
      chk("sext_pos_B", out_B, 32'h00007FFF);

      in_sign_ext = 1'b0;
      in_imm      = 16'h1111;
      in_aluop    = ALU_SUB;
      in_rd       = 5'd3;
      step();
      chk("pre_stall_B", out_B, 32'h00001111);
      out_ready = 1'b0;
      in_rs     = 5'd0;
      in_imm    = 16'h2222;
      in_aluop  = ALU_OR;
      in_rd     = 5'd4;
      wb_wen    = 1'b1;
      wb_waddr  = 5'd5;
      wb_wdata  = 32'hCAFEF00D;
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         wb_wen = 1'b0;
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_A", out_A, 32'hDEADBEEF);
         chk("stall_B", out_B, 32'h00001111);
         chk("stall_ALUop", out_ALUop, 3'b110);
         chk("stall_rd", out_rd, 5'd3);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1'b1);
      step();
      chk("release_A", out_A, 32'h0);
      chk("release_B", out_B, 32'h00002222);
      chk("release_ALUop", out_ALUop, 3'b001);
      chk("release_rd", out_rd, 5'd4);

      in_valid = 1'b0;
      wb_wen   = 1'b1;
      wb_waddr = 5'd7;
      wb_wdata = 32'd100;
      step();
      wb_wdata   = 32'd1234;
      in_valid   = 1'b1;
      in_rs      = 5'd7;
      in_rt      = 5'd7;
      in_use_imm = 1'b0;
`ifdef REGFILE_BYPASS_EN
      r7_expect = 32'd1234;
`else
      r7_expect = 32'd100;
`endif
      step();
      chk("byp_A", out_A, r7_expect);
      chk("byp_B", out_B, r7_expect);
      wb_wen = 1'b0;
      step();
      chk("r7_new_A", out_A, 32'd1234);
      chk("r7_new_B", out_B, 32'd1234);

      in_rs  = 5'd5;
      in_rd  = 5'd6;
      step();
      chk("r5_updated_A", out_A, 32'hCAFEF00D);
      out_ready = 1'b0;
      step();
      chk("mid_stall_valid", out_valid, 1'b1);
      rst      = 1'b1;
      wb_wen   = 1'b1;
      wb_waddr = 5'd9;
      wb_wdata = 32'h55;
      step();
      chk("rst_stall_valid", out_valid, 1'b0);
      chk("rst_stall_A", out_A, 32'h0);
      rst       = 1'b0;
      wb_wen    = 1'b0;
      out_ready = 1'b1;
      in_rs     = 5'd9;
      in_rt     = 5'd5;
      step();
      chk("dropped_wb_A", out_A, 32'h0);
      chk("cleared_r5_B", out_B, 32'h0);
      chk("post_rst_valid", out_valid, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares != 0) begin
         $error("TEST FAILED: %0d miscompares", miscompares);
      end else begin
         $display("TEST PASSED");
      end
      $finish;
   end

endmodule
